fetch_decode_queue: RTL
=======================

Name: fetch_decode_queue

Overview:
- Instruction queue between the fetch stage and the decode stage of the 5-stage MIPS pipeline.
- Buffers {pc, instr} pairs produced by fetch, so decode stalls do not throw away instruction-bus responses.
- Delivers pairs to decode in program order.
- Discards all buffered entries on a redirect (branch/jump taken, exception) signalled by flush.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- CW, $clog2(DEPTH)+1, occupancy counter width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  reset, asynchronous, active-low.
- flush  input  1  discard all entries this cycle; has priority over push and pop.
- in_valid  input  1  fetch presents a valid pair.
- in_pc  input  32  pc of the incoming instruction (pcF).
- in_instr  input  32  incoming instruction word (instrF).
- in_ready  output  1  queue can accept a pair this cycle.
- out_valid  output  1  head entry valid for decode.
- out_pc  output  32  pc of the head entry.
- out_instr  output  32  instruction word of the head entry.
- out_ready  input  1  decode consumes the head this cycle (~stall of decode).
- count  output  CW  current occupancy, 0..DEPTH.

Behaviour:
- State:
  - storage array DEPTH x 64 bits, {pc, instr};
  - wr_ptr and rd_ptr, each log2(DEPTH) bits;
  - occupancy counter cnt, CW bits.
- Reset (resetn low, asynchronous): wr_ptr=0, rd_ptr=0, cnt=0. Storage contents are not reset.
- Outputs immediately after reset: out_valid=0, in_ready=1, count=0, out_pc=0, out_instr=0.
- in_ready = (cnt != DEPTH). It depends only on registered state, never on out_ready or flush (no combinational path from decode to fetch).
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~flush.
- Push action: storage[wr_ptr] <= {in_pc, in_instr}; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- Pop action: rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- Counter update:
  - push only: cnt+1;
  - pop only: cnt-1;
  - push and pop together: cnt unchanged.
- Push and pop in the same cycle is legal whenever 0 < cnt < DEPTH.
- Full: in_ready=0, so fetch must hold its pair. A pop in that cycle frees a slot, and in_ready rises on the next cycle. No write-through when full.
- Empty:
  - out_valid=0; out_pc and out_instr are forced to 0 (decode sees a nop, sll $0,$0,0).
  - No bypass: a pair pushed at edge N is first visible at out_* after edge N, so fetch-to-decode latency is 1 cycle.
- out_valid = (cnt != 0).
- out_pc and out_instr are a combinational read of storage[rd_ptr], gated to 0 when empty.
- Flush (synchronous, sampled at the edge):
  - wr_ptr <= 0, rd_ptr <= 0, cnt <= 0.
  - A coincident push is dropped and a coincident pop does not occur.
  - out_valid=0 from the next cycle.
  - Flush while empty is a no-op.
  - Flush while fetch is stalled on full: in_ready=1 on the next cycle.
- Reset asserted mid-operation: state clears immediately (asynchronously), regardless of clk. Entries are lost with no drain.
- Pointer wrap: after DEPTH pushes and pops, the pointers return to 0. Ordering is preserved across the wrap.
- Ordering: out_pc sequence equals accepted in_pc sequence, excluding entries discarded by flush.
- Illegal-use checks (assertions in sim only):
  - cnt never exceeds DEPTH;
  - no pop when cnt==0;
  - in_pc is word-aligned on push.

Test Plan:
- Reset then idle, with in_valid=0 → out_valid=0, in_ready=1, count=0, out_pc=0, out_instr=0.
- Push pc=0xbfc00000 / instr=0x24080001, out_ready=0 → next cycle out_valid=1, out_pc=0xbfc00000, out_instr=0x24080001, count=1.
- Fill with out_ready=0 and pcs 0xbfc00000..0xbfc0000c (DEPTH=4) → count=4, in_ready=0. A fifth pair is held by fetch and not written. Raise out_ready for one cycle → head 0xbfc00000 popped, in_ready=1 next cycle, count=3.
- Streaming with in_valid=1 and out_ready=1 every cycle for 10 pairs → count stays 1 after the first cycle. Outputs appear in order with 1-cycle latency, and pointers wrap twice without reordering.
- Queue holding 3 entries; assert flush together with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0, no pop recorded, and the coincident pair is absent from later output.
- Deassert resetn asynchronously mid-cycle with count=2 → out_valid=0 and count=0 before the next clk edge. After release, the first push appears at out_pc correctly.

Source files
------------

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: buffers {pc, instr} pairs in program order
// and lets decode stall without losing instruction-bus responses.
module fetch_decode_queue #(
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          flush,
   input  logic          in_valid,
   input  logic [31:0]   in_pc,
   input  logic [31:0]   in_instr,
   output logic          in_ready,
   output logic          out_valid,
   output logic [31:0]   out_pc,
   output logic [31:0]   out_instr,
   input  logic          out_ready,
   output logic [CW-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [63:0]   storage [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          push;
   logic          pop;

   // in_ready looks only at registered occupancy, so decode stalls never reach fetch combinationally
   assign in_ready  = (cnt != FULL);
   assign out_valid = (cnt != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;
   assign count     = cnt;

   // An empty queue presents an all-zero word, which decode executes as a nop
   assign out_pc    = out_valid ? storage[rd_ptr][63:32] : '0;
   assign out_instr = out_valid ? storage[rd_ptr][31:0]  : '0;

   always_ff @(posedge clk) begin
      if (push) begin
         storage[wr_ptr] <= {in_pc, in_instr};
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

`ifndef SYNTHESIS
   a_cnt_bound: assert property (@(posedge clk) disable iff (!resetn) cnt <= FULL);
   a_no_empty_pop: assert property (@(posedge clk) disable iff (!resetn) !(pop && cnt == '0));
   a_pc_aligned: assert property (@(posedge clk) disable iff (!resetn) push |-> (in_pc[1:0] == 2'b00));
`endif

endmodule
